// File: rtl/risc_spm_core.sv
// risc_spm_core: 8-bit stored-program RISC processor (R0-R3, ALU + Z flag, PC/AR/IR,
// control FSM) with a 256x8 unified program/data memory instance M2_SRAM.
// Ports: clk (system clock, all state changes on rising edge),
//        rst (synchronous active-low reset; dominates every state including HALT).

// Purpose: 256-entry unified program/data store; contents survive reset.
// Latency: read is combinational from addr_i; write lands on the edge where we_i is high.
// Backpressure: none, every access completes in the cycle it is issued.
module risc_spm_sram #(
  parameter int WORD_SIZE = 8
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [WORD_SIZE-1:0] addr_i,
  input  logic [WORD_SIZE-1:0] wdata_i,
  output logic [WORD_SIZE-1:0] rdata_o
);

  logic [WORD_SIZE-1:0] memory [0:(1<<WORD_SIZE)-1];

  assign rdata_o = memory[addr_i];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      memory[addr_i] <= wdata_i;
    end
  end

endmodule

// Purpose: processor datapath and control; one register transfer per clock.
// Latency: NOP / BRZ-not-taken 3 FSM steps, ALU ops 4, RD/WR/BR/BRZ-taken 5.
// Backpressure: none; the core free-runs until HALT and only reset restarts it.
module risc_spm_core #(
  parameter int word_size = 8
) (
  input  logic clk,
  input  logic rst
);

  typedef enum logic [3:0] {
    S_IDLE, S_FET1, S_FET2, S_DEC, S_EX1,
    S_RD1, S_RD2, S_WR1, S_WR2, S_BR1, S_BR2, S_HALT
  } state_e;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_NOT = 4'h4;
  localparam logic [3:0] OP_RD  = 4'h5;
  localparam logic [3:0] OP_WR  = 4'h6;
  localparam logic [3:0] OP_BR  = 4'h7;
  localparam logic [3:0] OP_BRZ = 4'h8;

  localparam logic [word_size-1:0] ONE = 1;

  state_e state_q, state_d;

  // Architectural registers keep their bare names so they can be probed hierarchically.
  logic [word_size-1:0] R0, R1, R2, R3, PC, AR, IR, Y;
  logic                 Z;

  logic [word_size-1:0] r0_d, r1_d, r2_d, r3_d, pc_d, ar_d, ir_d, y_d;
  logic                 z_d;

  logic [3:0]           opcode;
  logic [1:0]           src, dest;
  logic [word_size-1:0] src_val, dest_val, alu_out, mem_rdata, reg_wdata;
  logic                 mem_we, reg_we;

  assign opcode = IR[7:4];
  assign src    = IR[3:2];
  assign dest   = IR[1:0];

  risc_spm_sram #(
    .WORD_SIZE (word_size)
  ) M2_SRAM (
    .clk_i   (clk),
    .we_i    (mem_we),
    .addr_i  (AR),
    .wdata_i (src_val),
    .rdata_o (mem_rdata)
  );

  always_comb begin
    src_val = R0;
    case (src)
      2'd1:    src_val = R1;
      2'd2:    src_val = R2;
      2'd3:    src_val = R3;
      default: src_val = R0;
    endcase
  end

  always_comb begin
    dest_val = R0;
    case (dest)
      2'd1:    dest_val = R1;
      2'd2:    dest_val = R2;
      2'd3:    dest_val = R3;
      default: dest_val = R0;
    endcase
  end

  // Y holds the source operand latched in DEC; NOT ignores the destination value.
  always_comb begin
    alu_out = ~Y;
    case (opcode)
      OP_ADD:  alu_out = dest_val + Y;
      OP_SUB:  alu_out = dest_val - Y;
      OP_AND:  alu_out = dest_val & Y;
      default: alu_out = ~Y;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = PC;
    ar_d      = AR;
    ir_d      = IR;
    y_d       = Y;
    z_d       = Z;
    mem_we    = 1'b0;
    reg_we    = 1'b0;
    reg_wdata = mem_rdata;

    case (state_q)
      S_IDLE: state_d = S_FET1;
      S_FET1: begin
        ar_d    = PC;
        state_d = S_FET2;
      end
      S_FET2: begin
        ir_d    = mem_rdata;
        pc_d    = PC + ONE;
        state_d = S_DEC;
      end
      S_DEC: begin
        case (opcode)
          OP_NOP: state_d = S_FET1;
          OP_ADD, OP_SUB, OP_AND, OP_NOT: begin
            y_d     = src_val;
            state_d = S_EX1;
          end
          OP_RD: begin
            ar_d    = PC;
            pc_d    = PC + ONE;
            state_d = S_RD1;
          end
          OP_WR: begin
            ar_d    = PC;
            pc_d    = PC + ONE;
            state_d = S_WR1;
          end
          OP_BR: begin
            ar_d    = PC;
            pc_d    = PC + ONE;
            state_d = S_BR1;
          end
          OP_BRZ: begin
            // Not taken: just step over the address byte without reading it.
            pc_d = PC + ONE;
            if (Z) begin
              ar_d    = PC;
              state_d = S_BR1;
            end else begin
              state_d = S_FET1;
            end
          end
          default: state_d = S_HALT;
        endcase
      end
      S_EX1: begin
        reg_we    = 1'b1;
        reg_wdata = alu_out;
        z_d       = (alu_out == '0);
        state_d   = S_FET1;
      end
      // RD1/WR1/BR1 all turn the address byte into the effective address.
      S_RD1: begin
        ar_d    = mem_rdata;
        state_d = S_RD2;
      end
      S_RD2: begin
        reg_we  = 1'b1;
        state_d = S_FET1;
      end
      S_WR1: begin
        ar_d    = mem_rdata;
        state_d = S_WR2;
      end
      S_WR2: begin
        // Memory has no reset, so a reset edge landing on WR2 must also suppress the store.
        mem_we  = rst;
        state_d = S_FET1;
      end
      S_BR1: begin
        ar_d    = mem_rdata;
        state_d = S_BR2;
      end
      S_BR2: begin
        pc_d    = mem_rdata;
        state_d = S_FET1;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase

    r0_d = (reg_we && dest == 2'd0) ? reg_wdata : R0;
    r1_d = (reg_we && dest == 2'd1) ? reg_wdata : R1;
    r2_d = (reg_we && dest == 2'd2) ? reg_wdata : R2;
    r3_d = (reg_we && dest == 2'd3) ? reg_wdata : R3;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      R0      <= '0;
      R1      <= '0;
      R2      <= '0;
      R3      <= '0;
      PC      <= '0;
      AR      <= '0;
      IR      <= '0;
      Y       <= '0;
      Z       <= 1'b0;
    end else begin
      state_q <= state_d;
      R0      <= r0_d;
      R1      <= r1_d;
      R2      <= r2_d;
      R3      <= r3_d;
      PC      <= pc_d;
      AR      <= ar_d;
      IR      <= ir_d;
      Y       <= y_d;
      Z       <= z_d;
    end
  end

endmodule

// File: tb/tb_risc_spm_core.sv
module tb_risc_spm_core;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  // Program image plus an instruction-level reference machine.
  logic [7:0] prog  [256];
  logic [7:0] m_mem [256];
  logic [7:0] m_r   [4];
  logic       m_z;
  logic [7:0] m_pc;
  logic       m_halted;

  always #5 clk = ~clk;

  risc_spm_core dut (
    .clk (clk),
    .rst (rst)
  );

  function automatic logic [7:0] dut_reg(input int i);
    case (i)
      0:       return dut.R0;
      1:       return dut.R1;
      2:       return dut.R2;
      default: return dut.R3;
    endcase
  endfunction

  task automatic clocks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) prog[i] = 8'h00;
  endtask

  // Hold reset, copy the image into DUT memory and the model, then release after one edge.
  task automatic start();
    rst = 1'b0;
    for (int i = 0; i < 256; i++) begin
      dut.M2_SRAM.memory[i] = prog[i];
      m_mem[i] = prog[i];
    end
    for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
    m_z = 1'b0;
    m_pc = 8'h00;
    clocks(1);
    rst = 1'b1;
  endtask

  // Executes whole instructions until a halting opcode; PC ends one past it.
  task automatic model_run();
    logic [7:0] ir, a, t;
    int steps;
    steps = 0;
    m_halted = 1'b0;
    while (!m_halted && steps < 5000) begin
      steps++;
      ir = m_mem[m_pc];
      m_pc = m_pc + 8'd1;
      case (ir[7:4])
        4'h0: ;
        4'h1, 4'h2, 4'h3, 4'h4: begin
          case (ir[7:4])
            4'h1:    t = m_r[ir[1:0]] + m_r[ir[3:2]];
            4'h2:    t = m_r[ir[1:0]] - m_r[ir[3:2]];
            4'h3:    t = m_r[ir[1:0]] & m_r[ir[3:2]];
            default: t = ~m_r[ir[3:2]];
          endcase
          m_r[ir[1:0]] = t;
          m_z = (t == 8'h00);
        end
        4'h5: begin a = m_mem[m_pc]; m_pc = m_pc + 8'd1; m_r[ir[1:0]] = m_mem[a]; end
        4'h6: begin a = m_mem[m_pc]; m_pc = m_pc + 8'd1; m_mem[a] = m_r[ir[3:2]]; end
        4'h7: begin a = m_mem[m_pc]; m_pc = m_mem[a]; end
        4'h8: begin
          if (m_z) begin a = m_mem[m_pc]; m_pc = m_mem[a]; end
          else m_pc = m_pc + 8'd1;
        end
        default: m_halted = 1'b1;
      endcase
    end
  endtask

  task automatic test_reset();
    logic [7:0] got [9];
    clear_prog();
    start();
    got = '{dut.R0, dut.R1, dut.R2, dut.R3, dut.PC, dut.AR, dut.IR, dut.Y, {7'd0, dut.Z}};
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (got[i] !== 8'h00) begin
        errors++;
        $display("FAIL reset_value[%0d]: got %02h expected 00", i, got[i]);
      end
    end
  endtask

  task automatic test_loop();
    logic [7:0] code [15];
    logic [7:0] got [6];
    logic [7:0] expv [6];
    int bad;
    code = '{8'h00, 8'h52, 8'd130, 8'h53, 8'd131, 8'h51, 8'd128, 8'h50, 8'd129,
             8'h21, 8'h80, 8'd134, 8'h1B, 8'h70, 8'd140};
    clear_prog();
    for (int i = 0; i < 15; i++) prog[i] = code[i];
    prog[128] = 8'd6;  prog[129] = 8'd1;  prog[130] = 8'd2;  prog[131] = 8'd0;
    prog[134] = 8'd139; prog[139] = 8'hF0; prog[140] = 8'd9;
    start();
    clocks(400);
    model_run();
    expv = '{8'd1, 8'd0, 8'd2, 8'd10, 8'd140, 8'd1};
    got  = '{dut.R0, dut.R1, dut.R2, dut.R3, dut.PC, {7'd0, dut.Z}};
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (got[i] !== expv[i]) begin
        errors++;
        $display("FAIL loop_result[%0d]: got %0d expected %0d", i, got[i], expv[i]);
      end
    end
    checks++;
    if (m_r[3] !== 8'd10 || m_pc !== 8'd140 || !m_halted) begin
      errors++;
      $display("FAIL loop_model: model R3=%0d PC=%0d expected 10/140", m_r[3], m_pc);
    end
    bad = 0;
    for (int i = 0; i < 256; i++) if (dut.M2_SRAM.memory[i] !== prog[i]) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL loop_memory: %0d bytes changed, expected 0", bad);
    end
  endtask

  // Follows test_loop: the core sits in HALT, nothing may move for 100 more cycles.
  task automatic test_halt_hold();
    logic [7:0] got [8];
    logic [7:0] expv [8];
    int bad;
    clocks(100);
    expv = '{8'd1, 8'd0, 8'd2, 8'd10, 8'd140, 8'd139, 8'hF0, 8'd1};
    got  = '{dut.R0, dut.R1, dut.R2, dut.R3, dut.PC, dut.AR, dut.IR, {7'd0, dut.Z}};
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (got[i] !== expv[i]) begin
        errors++;
        $display("FAIL halt_hold[%0d]: got %02h expected %02h", i, got[i], expv[i]);
      end
    end
    bad = 0;
    for (int i = 0; i < 256; i++) if (dut.M2_SRAM.memory[i] !== prog[i]) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL halt_hold_memory: %0d bytes changed, expected 0", bad);
    end
  endtask

  task automatic test_rd_wr();
    clear_prog();
    prog[0] = 8'h50; prog[1] = 8'd128; prog[2] = 8'h60; prog[3] = 8'd200; prog[4] = 8'hF0;
    prog[128] = 8'h5A;
    start();
    clocks(60);
    checks++;
    if (dut.M2_SRAM.memory[200] !== 8'h5A) begin
      errors++;
      $display("FAIL rdwr_mem200: got %02h expected 5a", dut.M2_SRAM.memory[200]);
    end
    checks++;
    if (dut.R0 !== 8'h5A || dut.Z !== 1'b0 || dut.PC !== 8'd5) begin
      errors++;
      $display("FAIL rdwr_regs: R0=%02h Z=%0b PC=%0d expected 5a/0/5", dut.R0, dut.Z, dut.PC);
    end
  endtask

  task automatic test_alu();
    logic [7:0] ops [4];
    int         idx [4];
    logic [7:0] expv [4];
    logic       expz [4];
    ops  = '{8'h14, 8'h34, 8'h42, 8'h25};
    idx  = '{0, 0, 2, 1};
    expv = '{8'h10, 8'h20, 8'h0F, 8'h00};
    expz = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int c = 0; c < 4; c++) begin
      clear_prog();
      prog[0] = 8'h50; prog[1] = 8'd128; prog[2] = 8'h51; prog[3] = 8'd129;
      prog[4] = ops[c]; prog[5] = 8'hF0;
      prog[128] = 8'hF0; prog[129] = 8'h20;
      start();
      clocks(60);
      model_run();
      checks++;
      if (dut_reg(idx[c]) !== expv[c] || dut.Z !== expz[c]) begin
        errors++;
        $display("FAIL alu_op%02h: R%0d=%02h Z=%0b expected %02h/%0b",
                 ops[c], idx[c], dut_reg(idx[c]), dut.Z, expv[c], expz[c]);
      end
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (dut_reg(i) !== m_r[i]) begin
          errors++;
          $display("FAIL alu_op%02h_R%0d: got %02h expected %02h", ops[c], i, dut_reg(i), m_r[i]);
        end
      end
    end
  endtask

  // Records the first cycle AR points at each address; fetch starts are where AR takes the next PC.
  task automatic test_brz_not_taken();
    int t [256];
    int nop_len;
    logic saw_target;
    clear_prog();
    prog[0] = 8'h41;
    prog[10] = 8'h80; prog[11] = 8'd150; prog[12] = 8'h10; prog[13] = 8'hF0;
    prog[150] = 8'd99;
    for (int i = 0; i < 256; i++) t[i] = -1;
    saw_target = 1'b0;
    start();
    for (int c = 1; c <= 150; c++) begin
      clocks(1);
      if (t[dut.AR] < 0) t[dut.AR] = c;
      if (dut.PC == 8'd99) saw_target = 1'b1;
    end
    nop_len = t[2] - t[1];
    checks++;
    if (t[11] != -1 || t[150] != -1 || saw_target) begin
      errors++;
      $display("FAIL brz_nt_no_target: AR11@%0d AR150@%0d pc99=%0b expected none", t[11], t[150], saw_target);
    end
    checks++;
    if (t[12] < 0 || t[12] - t[10] != nop_len) begin
      errors++;
      $display("FAIL brz_nt_cycles: got %0d expected %0d (NOP length)", t[12] - t[10], nop_len);
    end
    checks++;
    if (t[13] - t[12] != nop_len + 1) begin
      errors++;
      $display("FAIL brz_nt_alu_cycles: got %0d expected %0d", t[13] - t[12], nop_len + 1);
    end
    checks++;
    if (dut.PC !== 8'd14 || dut.R1 !== 8'hFF) begin
      errors++;
      $display("FAIL brz_nt_final: PC=%0d R1=%02h expected 14/ff", dut.PC, dut.R1);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] got [8];
    clear_prog();
    prog[0] = 8'h51; prog[1] = 8'd128; prog[2] = 8'hF0; prog[128] = 8'h77;
    start();
    clocks(5);  // IDLE, FET1, FET2, DEC, RD1 done: next edge is RD2
    checks++;
    if (dut.AR !== 8'd128) begin
      errors++;
      $display("FAIL rstmid_pre_ar: got %02h expected 80", dut.AR);
    end
    rst = 1'b0;
    clocks(1);
    rst = 1'b1;
    got = '{dut.R0, dut.R1, dut.R2, dut.R3, dut.PC, dut.AR, dut.IR, {7'd0, dut.Z}};
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (got[i] !== 8'h00) begin
        errors++;
        $display("FAIL rstmid_zero[%0d]: got %02h expected 00", i, got[i]);
      end
    end
    clocks(3);
    checks++;
    if (dut.IR !== 8'h51 || dut.PC !== 8'd1 || dut.AR !== 8'd0) begin
      errors++;
      $display("FAIL rstmid_refetch: IR=%02h PC=%0d AR=%0d expected 51/1/0", dut.IR, dut.PC, dut.AR);
    end
    clocks(20);
    checks++;
    if (dut.R1 !== 8'h77) begin
      errors++;
      $display("FAIL rstmid_rerun: R1=%02h expected 77", dut.R1);
    end
  endtask

  // BR to 255; the RD there takes its address byte from location 0; then an illegal opcode halts.
  task automatic test_wrap();
    clear_prog();
    prog[0] = 8'h70; prog[1] = 8'd200; prog[200] = 8'd255; prog[255] = 8'h52;
    prog[112] = 8'h3C;
    start();
    clocks(60);
    model_run();
    checks++;
    if (dut.R2 !== 8'h3C || dut.PC !== 8'd2) begin
      errors++;
      $display("FAIL wrap: R2=%02h PC=%0d expected 3c/2", dut.R2, dut.PC);
    end
    checks++;
    if (dut.R2 !== m_r[2] || dut.PC !== m_pc) begin
      errors++;
      $display("FAIL wrap_model: R2=%02h PC=%0d expected %02h/%0d", dut.R2, dut.PC, m_r[2], m_pc);
    end
  endtask

  task automatic test_random();
    logic [3:0] op;
    logic [1:0] s, d;
    int pc, bad;
    for (int it = 0; it < 4; it++) begin
      clear_prog();
      for (int a = 128; a < 256; a++) prog[a] = 8'($urandom);
      pc = 0;
      for (int k = 0; k < 16; k++) begin
        op = 4'($urandom_range(0, 6));
        s  = 2'($urandom_range(0, 3));
        d  = 2'($urandom_range(0, 3));
        prog[pc] = {op, s, d};
        pc++;
        if (op == 4'h5 || op == 4'h6) begin
          prog[pc] = 8'($urandom_range(128, 255));
          pc++;
        end
      end
      prog[pc] = 8'hF0;
      start();
      clocks(300);
      model_run();
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (dut_reg(i) !== m_r[i]) begin
          errors++;
          $display("FAIL random%0d_R%0d: got %02h expected %02h", it, i, dut_reg(i), m_r[i]);
        end
      end
      checks++;
      if (dut.PC !== m_pc || dut.Z !== m_z) begin
        errors++;
        $display("FAIL random%0d_pc_z: PC=%0d Z=%0b expected %0d/%0b", it, dut.PC, dut.Z, m_pc, m_z);
      end
      bad = 0;
      for (int i = 0; i < 256; i++) if (dut.M2_SRAM.memory[i] !== m_mem[i]) bad++;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL random%0d_memory: %0d bytes differ, expected 0", it, bad);
      end
    end
  endtask

  initial begin
    test_reset();
    test_loop();
    test_halt_hold();
    test_rd_wr();
    test_alu();
    test_brz_not_taken();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
